// File: rtl/atmega_uart_bus_bridge.sv
// UART debug initiator for the ATMEGA IO bus.
// Host sends 'W' addr data (write, ACK reply) or 'R' addr (read, data reply).
module atmega_uart_bus_bridge #(
    parameter int         BUS_ADDR_DATA_LEN = 8,
    parameter int         CLK_DIV           = 868,
    parameter int         TIMEOUT_BITS      = 32,
    parameter logic [7:0] ACK_BYTE          = 8'h4B
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         rx_i,
    output logic                         tx_o,
    output logic [BUS_ADDR_DATA_LEN-1:0] addr_o,
    output logic                         wr_o,
    output logic                         rd_o,
    output logic [7:0]                   bus_o,
    input  logic [7:0]                   bus_i,
    output logic                         busy_o,
    output logic                         err_o
);

    localparam int CNT_W    = $clog2(CLK_DIV);
    localparam int TO_LIMIT = CLK_DIV * TIMEOUT_BITS;
    localparam int TO_W     = $clog2(TO_LIMIT);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [TO_W-1:0]  TO_ZERO   = {TO_W{1'b0}};
    localparam logic [TO_W-1:0]  TO_ONE    = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_LIMIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {
        ST_CMD, ST_ADDR, ST_WDATA, ST_EXEC_WR, ST_EXEC_RD, ST_REPLY
    } state_t;

    logic [1:0]       r_rx_sync;
    logic             r_rx_prev;
    rx_state_t        r_rx_state, w_rx_state_nxt;
    logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_nxt;
    logic [2:0]       r_rx_bits, w_rx_bits_nxt;
    logic [7:0]       r_rx_shift, w_rx_shift_nxt;
    logic             r_byte_vld, w_byte_vld_nxt;
    logic             r_frm_err, w_frm_err_nxt;
    logic             w_rx_bit;

    state_t                       r_state, w_state_nxt;
    logic                         r_mode_rd;
    logic [BUS_ADDR_DATA_LEN-1:0] r_addr;
    logic [7:0]                   r_wdata;
    logic [7:0]                   r_reply;
    logic [TO_W-1:0]              r_to_cnt;
    logic                         r_wr, r_rd, r_err, r_busy;
    logic                         w_err_nxt, w_tx_load, w_to_exp, w_to_state;
    logic [7:0]                   w_tx_data;

    logic             r_tx_busy, r_tx;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [3:0]       r_tx_bit;
    logic [9:0]       r_tx_shift;
    logic             w_tx_last, w_tx_busy_nxt;

    assign w_rx_bit = r_rx_sync[1];

    // Synchroniser and RX frame registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_rx_sync  <= 2'b11;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= CNT_ZERO;
            r_rx_bits  <= 3'd0;
            r_rx_shift <= 8'h00;
            r_byte_vld <= 1'b0;
            r_frm_err  <= 1'b0;
        end else begin
            r_rx_sync  <= {r_rx_sync[0], rx_i};
            r_rx_prev  <= r_rx_sync[1];
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bits  <= w_rx_bits_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_byte_vld <= w_byte_vld_nxt;
            r_frm_err  <= w_frm_err_nxt;
        end
    end

    // RX next-state: mid-bit sampling driven by a down-counter
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt;
        w_rx_bits_nxt  = r_rx_bits;
        w_rx_shift_nxt = r_rx_shift;
        w_byte_vld_nxt = 1'b0;
        w_frm_err_nxt  = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (r_rx_prev && !w_rx_bit) begin
                    w_rx_state_nxt = RX_START;
                    w_rx_cnt_nxt   = HALF_LOAD;
                end else begin
                    w_rx_cnt_nxt = CNT_ZERO;
                end
            end
            RX_START: begin
                if (r_rx_cnt != CNT_ZERO) begin
                    w_rx_cnt_nxt = r_rx_cnt - CNT_ONE;
                end else if (!w_rx_bit) begin
                    w_rx_state_nxt = RX_DATA;
                    w_rx_cnt_nxt   = DIV_LOAD;
                    w_rx_bits_nxt  = 3'd0;
                end else begin
                    w_rx_state_nxt = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt != CNT_ZERO) begin
                    w_rx_cnt_nxt = r_rx_cnt - CNT_ONE;
                end else begin
                    w_rx_shift_nxt = {w_rx_bit, r_rx_shift[7:1]};
                    w_rx_cnt_nxt   = DIV_LOAD;
                    if (r_rx_bits == 3'd7) begin
                        w_rx_state_nxt = RX_STOP;
                    end else begin
                        w_rx_bits_nxt = r_rx_bits + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (r_rx_cnt != CNT_ZERO) begin
                    w_rx_cnt_nxt = r_rx_cnt - CNT_ONE;
                end else begin
                    w_byte_vld_nxt = w_rx_bit;
                    w_frm_err_nxt  = !w_rx_bit;
                    w_rx_state_nxt = RX_IDLE;
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    assign w_to_state = (r_state == ST_ADDR) || (r_state == ST_WDATA);
    assign w_to_exp   = w_to_state && !r_byte_vld && (r_to_cnt == TO_LAST);

    // Parser next-state; errors are OR-ed so coincident causes give one pulse
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        w_tx_load   = 1'b0;
        w_tx_data   = r_reply;
        if (r_frm_err || w_to_exp) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_CMD;
        end else begin
            case (r_state)
                ST_CMD: begin
                    if (r_byte_vld && (r_rx_shift == 8'h57 || r_rx_shift == 8'h52)) begin
                        w_state_nxt = ST_ADDR;
                    end else begin
                        w_err_nxt = r_byte_vld;
                    end
                end
                ST_ADDR: begin
                    if (r_byte_vld) begin
                        w_state_nxt = r_mode_rd ? ST_EXEC_RD : ST_WDATA;
                    end else begin
                        w_state_nxt = ST_ADDR;
                    end
                end
                ST_WDATA: begin
                    if (r_byte_vld) begin
                        w_state_nxt = ST_EXEC_WR;
                    end else begin
                        w_state_nxt = ST_WDATA;
                    end
                end
                ST_EXEC_WR, ST_EXEC_RD: begin
                    // Launch the reply straight away when TX is free so the
                    // start bit follows the strobe by one cycle.
                    w_tx_data = (r_state == ST_EXEC_RD) ? bus_i : ACK_BYTE;
                    w_tx_load = !r_tx_busy;
                    w_state_nxt = r_tx_busy ? ST_REPLY : ST_CMD;
                end
                ST_REPLY: begin
                    w_err_nxt = r_byte_vld;
                    if (!r_tx_busy) begin
                        w_tx_load   = 1'b1;
                        w_state_nxt = ST_CMD;
                    end else begin
                        w_state_nxt = ST_REPLY;
                    end
                end
                default: w_state_nxt = ST_CMD;
            endcase
        end
    end

    assign w_tx_last     = (r_tx_cnt == CNT_ZERO) && (r_tx_bit == 4'd9);
    assign w_tx_busy_nxt = w_tx_load || (r_tx_busy && !w_tx_last);

    // Parser state, latched fields, timeout and registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state   <= ST_CMD;
            r_mode_rd <= 1'b0;
            r_addr    <= {BUS_ADDR_DATA_LEN{1'b0}};
            r_wdata   <= 8'h00;
            r_reply   <= 8'h00;
            r_to_cnt  <= TO_ZERO;
            r_wr      <= 1'b0;
            r_rd      <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wr    <= (w_state_nxt == ST_EXEC_WR);
            r_rd    <= (w_state_nxt == ST_EXEC_RD);
            r_err   <= w_err_nxt;
            r_busy  <= (w_state_nxt != ST_CMD) || w_tx_busy_nxt;
            if (r_state == ST_CMD && r_byte_vld) begin
                r_mode_rd <= (r_rx_shift == 8'h52);
            end
            if (r_state == ST_ADDR && r_byte_vld) begin
                r_addr <= r_rx_shift[BUS_ADDR_DATA_LEN-1:0];
            end
            if (r_state == ST_WDATA && r_byte_vld) begin
                r_wdata <= r_rx_shift;
            end
            if (r_state == ST_EXEC_WR || r_state == ST_EXEC_RD) begin
                r_reply <= w_tx_data;
            end
            r_to_cnt <= (w_to_state && !r_byte_vld) ? r_to_cnt + TO_ONE : TO_ZERO;
        end
    end

    // TX shifter: start, 8 data bits LSB first, stop
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_tx_busy  <= 1'b0;
            r_tx       <= 1'b1;
            r_tx_cnt   <= CNT_ZERO;
            r_tx_bit   <= 4'd0;
            r_tx_shift <= 10'h3FF;
        end else if (w_tx_load) begin
            r_tx_busy  <= 1'b1;
            r_tx       <= 1'b0;
            r_tx_cnt   <= DIV_LOAD;
            r_tx_bit   <= 4'd0;
            r_tx_shift <= {1'b1, w_tx_data, 1'b0};
        end else if (r_tx_busy) begin
            if (r_tx_cnt != CNT_ZERO) begin
                r_tx_cnt <= r_tx_cnt - CNT_ONE;
            end else if (r_tx_bit == 4'd9) begin
                r_tx_busy <= 1'b0;
                r_tx      <= 1'b1;
            end else begin
                r_tx_bit   <= r_tx_bit + 4'd1;
                r_tx       <= r_tx_shift[1];
                r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                r_tx_cnt   <= DIV_LOAD;
            end
        end
    end

    assign tx_o   = r_tx;
    assign addr_o = r_addr;
    assign wr_o   = r_wr;
    assign rd_o   = r_rd;
    assign bus_o  = r_wdata;
    assign busy_o = r_busy;
    assign err_o  = r_err;

endmodule

// File: tb/tb_atmega_uart_bus_bridge.sv
// Directed bench for atmega_uart_bus_bridge: table of bus transactions plus
// hand-written reset, bad-command, framing, timeout and mid-reply reset cases.
module tb_atmega_uart_bus_bridge;

    localparam int DIV = 16;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] addr;
        logic [7:0] data;
        logic       is_rd;
        logic [7:0] exp_reply;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       tx;
    logic [7:0] addr;
    logic       wr;
    logic       rd;
    logic [7:0] bus_w;
    logic [7:0] bus_r;
    logic       busy;
    logic       err;

    int n_cmp = 0, n_fail = 0, cyc = 0;
    int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, both_cnt = 0;
    int wr_cyc = 0, rd_cyc = 0;
    logic [7:0] wr_addr, wr_bus, rd_addr;
    int dec_cnt = 0, dec_len = 0, dec_fall = 0;
    logic [7:0] dec_byte;
    logic dec_stop;
    vec_t vecs [5];

    atmega_uart_bus_bridge #(
        .BUS_ADDR_DATA_LEN(8),
        .CLK_DIV(DIV),
        .TIMEOUT_BITS(512),
        .ACK_BYTE(8'h4B)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .rx_i(rx),
        .tx_o(tx),
        .addr_o(addr),
        .wr_o(wr),
        .rd_o(rd),
        .bus_o(bus_w),
        .bus_i(bus_r),
        .busy_o(busy),
        .err_o(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: 0x60 at 0xC8, inverted address elsewhere
    always_comb bus_r = (addr == 8'hC8) ? 8'h60 : ~addr;

    always @(negedge clk) begin
        if (wr === 1'b1) begin wr_cnt++; wr_cyc = cyc; wr_addr = addr; wr_bus = bus_w; end
        if (rd === 1'b1) begin rd_cnt++; rd_cyc = cyc; rd_addr = addr; end
        if (err === 1'b1) err_cnt++;
        if (wr === 1'b1 && rd === 1'b1) both_cnt++;
    end

    // Reply decoder: samples mid-bit, measures start edge to end of busy
    initial begin : decoder
        logic       prev;
        logic [7:0] b;
        int         st, n;
        prev = 1'b1;
        b    = 8'h00;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && tx === 1'b0) begin
                st = cyc;
                repeat (DIV / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b = {tx, b[7:1]};
                end
                repeat (DIV) @(negedge clk);
                dec_stop = tx;
                n = 0;
                while (busy === 1'b1 && n < 64) begin @(negedge clk); n++; end
                dec_len  = cyc - st;
                dec_fall = st;
                dec_byte = b;
                dec_cnt++;
            end
            prev = tx;
        end
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        int w0, r0, e0, d0, n;
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; d0 = dec_cnt;
        send_byte(v.cmd, 1'b1);
        send_byte(v.addr, 1'b1);
        if (!v.is_rd) send_byte(v.data, 1'b1);
        n = 0;
        while (dec_cnt == d0 && n < 400) begin @(negedge clk); n++; end
        chk({tag, " reply_frames"}, dec_cnt - d0, 1);
        chk({tag, " wr_pulses"}, wr_cnt - w0, v.is_rd ? 0 : 1);
        chk({tag, " rd_pulses"}, rd_cnt - r0, v.is_rd ? 1 : 0);
        if (v.is_rd) begin
            chk({tag, " rd_addr"}, rd_addr, v.addr);
            chk({tag, " rd_to_start"}, dec_fall - rd_cyc, 1);
        end else begin
            chk({tag, " wr_addr"}, wr_addr, v.addr);
            chk({tag, " wr_bus"}, wr_bus, v.data);
            chk({tag, " wr_to_start"}, dec_fall - wr_cyc, 1);
        end
        chk({tag, " reply_byte"}, dec_byte, v.exp_reply);
        chk({tag, " reply_stop"}, dec_stop, 1'b1);
        chk({tag, " frame_len"}, dec_len, 10 * DIV);
        chk({tag, " no_err"}, err_cnt - e0, 0);
    endtask

    initial begin
        int   e0, w0, r0, n;
        vec_t v;
        vecs[0] = '{8'h57, 8'h3C, 8'hA5, 1'b0, 8'h4B};
        vecs[1] = '{8'h52, 8'hC8, 8'h00, 1'b1, 8'h60};
        vecs[2] = '{8'h57, 8'hFF, 8'h00, 1'b0, 8'h4B};
        vecs[3] = '{8'h52, 8'h33, 8'h00, 1'b1, 8'hCC};
        vecs[4] = '{8'h57, 8'h80, 8'h7E, 1'b0, 8'h4B};

        // Reset held 3 cycles with rx toggling
        rst_n = 1'b0;
        rx    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rx = ~rx;
        end
        chk("rst tx", tx, 1'b1);
        chk("rst wr", wr, 1'b0);
        chk("rst rd", rd, 1'b0);
        chk("rst addr", addr, 8'h00);
        chk("rst bus", bus_w, 8'h00);
        chk("rst busy", busy, 1'b0);
        chk("rst err", err, 1'b0);
        rx    = 1'b1;
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("post_rst strobes", wr_cnt + rd_cnt, 0);
        chk("post_rst err", err_cnt, 0);
        chk("post_rst busy", busy, 1'b0);

        for (int i = 0; i < 5; i++) begin
            do_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Unknown command byte
        e0 = err_cnt; w0 = wr_cnt; r0 = rd_cnt;
        send_byte(8'h00, 1'b1);
        chk("badcmd err", err_cnt - e0, 1);
        chk("badcmd strobes", (wr_cnt - w0) + (rd_cnt - r0), 0);
        chk("badcmd busy", busy, 1'b0);
        v = '{8'h57, 8'h10, 8'h01, 1'b0, 8'h4B};
        do_txn(v, "after_badcmd");

        // Framing error on the address byte
        e0 = err_cnt; w0 = wr_cnt; r0 = rd_cnt;
        send_byte(8'h57, 1'b1);
        send_byte(8'h3C, 1'b0);
        chk("frm err", err_cnt - e0, 1);
        chk("frm strobes", (wr_cnt - w0) + (rd_cnt - r0), 0);
        chk("frm busy", busy, 1'b0);

        // Inter-byte timeout, then the stray byte is taken as a bad command
        e0 = err_cnt; w0 = wr_cnt; r0 = rd_cnt;
        send_byte(8'h57, 1'b1);
        repeat (7900) @(negedge clk);
        chk("timeout early", err_cnt - e0, 0);
        n = 0;
        while (err_cnt == e0 && n < 800) begin @(negedge clk); n++; end
        chk("timeout err", err_cnt - e0, 1);
        chk("timeout busy", busy, 1'b0);
        send_byte(8'h3C, 1'b1);
        chk("timeout stray err", err_cnt - e0, 2);
        chk("timeout strobes", (wr_cnt - w0) + (rd_cnt - r0), 0);

        // Reset during a read reply
        send_byte(8'h52, 1'b1);
        send_byte(8'hC8, 1'b1);
        n = 0;
        while (tx !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        repeat (40) @(negedge clk);
        chk("midrst tx_low_before", tx, 1'b0);
        w0 = wr_cnt; r0 = rd_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst tx_high", tx, 1'b1);
        chk("midrst busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("midrst strobes", (wr_cnt - w0) + (rd_cnt - r0), 0);
        chk("midrst tx_idle", tx, 1'b1);
        v = '{8'h52, 8'hC8, 8'h00, 1'b1, 8'h60};
        do_txn(v, "after_midrst");

        chk("wr_rd_exclusive", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/atmega_uart_bus_bridge.md
# atmega_uart_bus_bridge

Serial debug initiator for the ATMEGA IO bus, the bus-master counterpart of the bus-slave UART peripheral. It receives 8N1 command frames on `rx_i`, drives single-cycle `wr_o` or `rd_o` transactions on the IO bus, and returns an acknowledge or read-data byte on `tx_o`. It lets a host PC peek and poke every IO register (UART, timers, ports) without CPU involvement.

## Interface
- `BUS_ADDR_DATA_LEN`, 8: IO address width, legal range 1..8; `addr_o` takes the low bits of the address byte.
- `CLK_DIV`, 868: clock cycles per bit, minimum 8.
- `TIMEOUT_BITS`, 32: inter-byte timeout, in bit-times.
- `ACK_BYTE`, 8'h4B: reply byte sent after a write.

Ports:
- `clk_i` in 1: the single clock.
- `rst_n_i` in 1: synchronous, active-low reset.
- `rx_i` in 1: serial input, asynchronous, idle high.
- `tx_o` out 1: serial output, idle high.
- `addr_o` out BUS_ADDR_DATA_LEN: IO bus address.
- `wr_o` out 1: write strobe, one cycle.
- `rd_o` out 1: read strobe, one cycle.
- `bus_o` out 8: write data.
- `bus_i` in 8: read data, combinational from the slaves during `rd_o`.
- `busy_o` out 1: high whenever the parser is not in CMD or TX is active.
- `err_o` out 1: one-cycle pulse on a protocol error.

## Operation
- **RX synchroniser.** `rx_i` passes through a 2-flop synchroniser.
- **RX frame detection.**
  - In RX idle, a synchronised falling edge loads the counter with CLK_DIV/2−1.
  - At expiry the start bit is re-sampled; if it reads high, the event is a false start and RX returns to idle silently.
  - Eight data bits follow, LSB first, each sampled every CLK_DIV cycles.
  - The stop bit is sampled at mid-bit. High produces a one-cycle `byte_vld`; low produces `frm_err`. RX then returns to idle immediately.
- **TX.** TX loads a byte and shifts out start(0), d0..d7, stop(1), each bit lasting CLK_DIV cycles. TX goes idle at the end of the stop bit.
- **Parser states.** CMD, ADDR, WDATA, EXEC_WR, EXEC_RD, REPLY.
  - CMD:
    - `byte_vld` with 8'h57 ('W') goes to ADDR, with mode write.
    - 8'h52 ('R') goes to ADDR, with mode read.
    - Any other byte pulses `err_o` and stays in CMD.
  - ADDR: latch the address. Write mode goes to WDATA; read mode goes to EXEC_RD.
  - WDATA: latch the data and go to EXEC_WR.
  - EXEC_WR: assert `wr_o` for one cycle with `addr_o`/`bus_o` valid, then go to REPLY with ACK_BYTE.
  - EXEC_RD: assert `rd_o` for one cycle and capture `bus_i` in that same cycle, then go to REPLY with the captured byte.
  - REPLY: when TX is idle, load TX and go to CMD. Any `byte_vld` received in REPLY is dropped and pulses `err_o`.
- **Framing error.** `frm_err` in any state pulses `err_o`, returns the parser to CMD, and issues no bus cycle.
- **Timeout.** The timeout counter counts CLK_DIV×TIMEOUT_BITS cycles in ADDR and WDATA and restarts on every `byte_vld`. Expiry pulses `err_o` and returns to CMD.
- **Simultaneous events.** `frm_err` and timeout expiry in the same cycle produce a single `err_o` pulse.
- **Quiescent outputs.** `addr_o` and `bus_o` hold their last values; they are meaningful only while a strobe is high.

## Timing
- **Reset values:** `tx_o`=1, `wr_o`=0, `rd_o`=0, `addr_o`=0, `bus_o`=0, `busy_o`=0, `err_o`=0. The parser is in CMD, RX and TX are idle, and all counters are 0.
- **Reset mid-operation.**
  - Reset mid-frame aborts both RX and TX.
  - `tx_o` returns high in the cycle after reset is sampled.
  - No strobe is issued.
- **Byte decode:** `byte_vld` occurs 1 cycle after the stop-bit mid-sample.
- **Write path:**
  - `wr_o` is high exactly 1 cycle, in the cycle after WDATA's `byte_vld`.
  - The ACK start bit (`tx_o` falling) appears in the cycle after `wr_o`.
- **Read path:**
  - `rd_o` is high exactly 1 cycle, in the cycle after ADDR's `byte_vld`.
  - `tx_o` falls in the cycle after `rd_o`.
- **Reply frame:** exactly 10×CLK_DIV cycles from the start-bit edge to the end of the stop bit.
- **Mutual exclusion:** `wr_o` and `rd_o` are never high together.

## Test plan
- **Reset:** `rst_n_i`=0 for 3 cycles while `rx_i` toggles -> all outputs at reset values, no strobe.
- **Write** (CLK_DIV=16): send 8'h57, 8'h3C, 8'hA5 -> exactly one `wr_o` pulse with `addr_o`=8'h3C and `bus_o`=8'hA5, then a TX frame carrying 8'h4B of 160 cycles.
- **Read:** `bus_i`=8'h60 when `addr_o`==8'hC8; send 8'h52, 8'hC8 -> one `rd_o` pulse, `tx_o` falls the next cycle, and the decoded TX byte is 8'h60.
- **Bad command:** send 8'h00 -> one `err_o` pulse and no strobe; a following write of 8'h57, 8'h10, 8'h01 completes normally.
- **Framing error and timeout:**
  - Send 8'h57, then 8'h3C with stop bit low -> `err_o` pulse, parser back in CMD, no `wr_o`.
  - Separately, send 8'h57 and idle for 513 bit-times×16 cycles -> `err_o` pulse; then 8'h3C is treated as a command and rejected.
- **Reset mid-operation:** assert reset mid-way through a read reply -> `tx_o`=1 in the next cycle; after release, a new read returns correct data.
